// File: rtl/hammer_strike_controller.sv
// hammer_strike_controller
// Runs a hammer strike once the inventory counter issues a one-cycle
// use_hammer pulse. The strike moves through swing animation, a lethal
// active window and a cooldown, all paced by startOfFrame pulses. While
// active, collision reports become kill pulses, at most one per frame.
// Optional feature macro: HAMMER_KILL_LIMIT_EN caps kills per strike at
// MAX_KILLS. When the macro is undefined no kill counter is built.
module hammer_strike_controller #(
  parameter int SWING_FRAMES    = 4,
  parameter int ACTIVE_FRAMES   = 20,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int MAX_KILLS       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       use_hammer,
  input  logic       startOfFrame,
  input  logic       collision,
  output logic       hammer_draw,
  output logic [1:0] anim_frame,
  output logic       hammer_active,
  output logic       kill_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SWING    = 2'd1,
    S_ACTIVE   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  localparam logic [7:0] SWING_F  = 8'(SWING_FRAMES);
  localparam logic [7:0] ACTIVE_F = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] COOL_F   = 8'(COOLDOWN_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       flag_q, flag_d;   // a kill was already taken this frame
  logic       kill_q, kill_d;
  logic [7:0] fcnt_inc;
  logic       kill_ok;          // kill budget for this strike not exhausted

  assign fcnt_inc = fcnt_q + 8'd1;

`ifdef HAMMER_KILL_LIMIT_EN
  localparam logic [2:0] KILL_CAP = 3'(MAX_KILLS);
  logic [2:0] kcnt_q, kcnt_d;

  assign kill_ok = (kcnt_q != KILL_CAP);

  // Kill counter register, cleared on every entry to ACTIVE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) kcnt_q <= 3'd0;
    else       kcnt_q <= kcnt_d;
  end
`else
  // Without the cap the per-frame flag is the only limiter.
  assign kill_ok = 1'b1;
`endif

  // State, frame counter, frame flag and kill strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      fcnt_q  <= 8'd0;
      flag_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flag_q  <= flag_d;
      kill_q  <= kill_d;
    end
  end

  // Next-state logic: frame pacing per state plus kill generation in ACTIVE
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flag_d  = flag_q;
    kill_d  = 1'b0;
`ifdef HAMMER_KILL_LIMIT_EN
    kcnt_d  = kcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A startOfFrame in the same cycle is deliberately not counted.
        if (use_hammer) begin
          state_d = S_SWING;
          fcnt_d  = 8'd0;
        end
      end
      S_SWING: begin
        if (startOfFrame) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc == SWING_F) begin
            state_d = S_ACTIVE;
            fcnt_d  = 8'd0;
            flag_d  = 1'b0;
`ifdef HAMMER_KILL_LIMIT_EN
            kcnt_d  = 3'd0;
`endif
          end
        end
      end
      S_ACTIVE: begin
        if (startOfFrame) begin
          fcnt_d = fcnt_inc;
          flag_d = 1'b0;
          if (fcnt_inc == ACTIVE_F) begin
            fcnt_d  = 8'd0;
            state_d = (COOL_F == 8'd0) ? S_IDLE : S_COOLDOWN;
          end
        end
        // The frame clear takes effect first, so a collision coinciding
        // with startOfFrame is accepted and charged to the new frame.
        if (collision && (!flag_q || startOfFrame) && kill_ok) begin
          kill_d = 1'b1;
          flag_d = 1'b1;
`ifdef HAMMER_KILL_LIMIT_EN
          kcnt_d = kcnt_q + 3'd1;
`endif
        end
      end
      S_COOLDOWN: begin
        if (startOfFrame) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc == COOL_F) begin
            state_d = S_IDLE;
            fcnt_d  = 8'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = 8'd0;
      end
    endcase
  end

  // Sprite frame select: counting during swing, pinned at 3 while lethal
  always_comb begin
    anim_frame = 2'd0;
    case (state_q)
      S_SWING:  anim_frame = fcnt_q[1:0];
      S_ACTIVE: anim_frame = 2'd3;
      default:  anim_frame = 2'd0;
    endcase
  end

  assign hammer_draw   = (state_q == S_SWING) || (state_q == S_ACTIVE);
  assign hammer_active = (state_q == S_ACTIVE);
  assign busy          = (state_q != S_IDLE);
  assign kill_pulse    = kill_q;

endmodule
